// File: rtl/wb_pkg.sv
// Shared widths and the writeback entry type for the writeback unit.
package wb_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_unit_if.sv
// Writeback unit bus: issue/decode, ALU result, load result and register-file write port.
interface wb_unit_if #(
    parameter int DEPTH = 4
);
    import wb_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;

    logic              i_issue_valid;
    logic [REG_AW-1:0] i_issue_rd;
    logic [REG_AW-1:0] i_rs1_raddr;
    logic [REG_AW-1:0] i_rs2_raddr;
    logic              o_hazard;
    logic              i_alu_valid;
    logic [REG_AW-1:0] i_alu_rd;
    logic [XLEN-1:0]   i_alu_data;
    logic              i_ld_valid;
    logic              o_ld_ready;
    logic [REG_AW-1:0] i_ld_rd;
    logic [XLEN-1:0]   i_ld_data;
    logic              o_rd_wen;
    logic [REG_AW-1:0] o_rd_waddr;
    logic [XLEN-1:0]   o_rd_wdata;
    logic [CW-1:0]     o_ld_count;

    modport master (
        output i_issue_valid, i_issue_rd, i_rs1_raddr, i_rs2_raddr,
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_ld_valid, i_ld_rd, i_ld_data,
        input  o_hazard, o_ld_ready, o_rd_wen, o_rd_waddr, o_rd_wdata, o_ld_count
    );

    modport slave (
        input  i_issue_valid, i_issue_rd, i_rs1_raddr, i_rs2_raddr,
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_ld_valid, i_ld_rd, i_ld_data,
        output o_hazard, o_ld_ready, o_rd_wen, o_rd_waddr, o_rd_wdata, o_ld_count
    );
endinterface

// File: rtl/wb_fifo.sv
// Load-result FIFO; pointers carry one extra wrap bit to tell full from empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_entry_t
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  T                       i_wdata,
    input  logic                   i_pop,
    output T                       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    T             r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage is not reset; only the pointers define which slots are live.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_count = r_wptr - r_rptr;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

// File: rtl/wb_unit.sv
// Writeback initiator: ALU/load merge, registered write port and pending-write scoreboard.
// Define WB_BYPASS_EN when the register file forwards same-cycle writes to its read ports.
module wb_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic       i_clk,
    input logic       i_rst,
    wb_unit_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t         w_ld_entry;
    wb_entry_t         w_head;
    wb_entry_t         w_sel_entry;
    logic              w_push;
    logic              w_pop;
    logic              w_sel;
    logic              w_wen_next;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [NUM_REGS-1:0] w_busy_next;
    logic              w_inflight;

    logic              r_wen;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic [NUM_REGS-1:0] r_busy;

    assign w_ld_entry = wb_entry_t'{rd: bus.i_ld_rd, data: bus.i_ld_data};

    wb_fifo #(.DEPTH(DEPTH), .T(wb_entry_t)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_ld_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // ALU always wins; the FIFO head drains only in ALU bubbles.
    assign w_push      = bus.i_ld_valid && !w_full;
    assign w_pop       = !bus.i_alu_valid && !w_empty;
    assign w_sel       = bus.i_alu_valid || !w_empty;
    assign w_sel_entry = bus.i_alu_valid ? wb_entry_t'{rd: bus.i_alu_rd, data: bus.i_alu_data} : w_head;
    assign w_wen_next  = w_sel && (w_sel_entry.rd != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_wen_next;
            if (w_sel) begin
                r_waddr <= w_sel_entry.rd;
                r_wdata <= w_sel_entry.data;
            end
        end
    end

    // A new issue to the same register outranks the retiring write.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wen_next)        w_busy_next[w_sel_entry.rd] = 1'b0;
        if (bus.i_issue_valid) w_busy_next[bus.i_issue_rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_busy <= '0;
        else       r_busy <= w_busy_next;
    end

`ifdef WB_BYPASS_EN
    assign w_inflight = 1'b0;
`else
    assign w_inflight = r_wen &&
        (((r_waddr == bus.i_rs1_raddr) && (bus.i_rs1_raddr != '0)) ||
         ((r_waddr == bus.i_rs2_raddr) && (bus.i_rs2_raddr != '0)));
`endif

    assign bus.o_hazard   = r_busy[bus.i_rs1_raddr] || r_busy[bus.i_rs2_raddr] || w_inflight;
    assign bus.o_ld_ready = !w_full;
    assign bus.o_ld_count = w_count;
    assign bus.o_rd_wen   = r_wen;
    assign bus.o_rd_waddr = r_waddr;
    assign bus.o_rd_wdata = r_wdata;
endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: queue/array reference model plus directed literal checks and random traffic.
module tb_wb_unit;
    import wb_pkg::*;

    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_unit_if #(.DEPTH(DEPTH)) bus ();

    wb_unit #(.DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    wb_entry_t   q[$];
    bit          busy_m [NUM_REGS];
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        m_wen = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    function automatic bit model_hazard();
        bit h;
        h = busy_m[bus.i_rs1_raddr] | busy_m[bus.i_rs2_raddr];
        if (!BYP && m_wen &&
            ((m_waddr == bus.i_rs1_raddr && bus.i_rs1_raddr != 0) ||
             (m_waddr == bus.i_rs2_raddr && bus.i_rs2_raddr != 0)))
            h = 1'b1;
        return h;
    endfunction

    task automatic model_update();
        wb_entry_t s;
        bit        sel;
        int        pre;
        pre = q.size();
        sel = 1'b0;
        s   = '0;
        if (bus.i_alu_valid) begin
            sel = 1'b1;
            s.rd = bus.i_alu_rd;
            s.data = bus.i_alu_data;
        end else if (pre > 0) begin
            sel = 1'b1;
            s = q.pop_front();
        end
        if (bus.i_ld_valid && pre < DEPTH) q.push_back(wb_entry_t'{rd: bus.i_ld_rd, data: bus.i_ld_data});
        m_wen = sel && (s.rd != 0);
        if (sel) begin
            m_waddr = s.rd;
            m_wdata = s.data;
        end
        if (m_wen) busy_m[s.rd] = 1'b0;
        if (bus.i_issue_valid && bus.i_issue_rd != 0) busy_m[bus.i_issue_rd] = 1'b1;
    endtask

    task automatic compare_all();
        #1;
        chk("ld_count", 32'(bus.o_ld_count), 32'(q.size()));
        chk("ld_ready", 32'(bus.o_ld_ready), 32'(q.size() != DEPTH));
        chk("rd_wen",   32'(bus.o_rd_wen),   32'(m_wen));
        chk("rd_waddr", 32'(bus.o_rd_waddr), 32'(m_waddr));
        chk("rd_wdata", bus.o_rd_wdata,      m_wdata);
        chk("hazard",   32'(bus.o_hazard),   32'(model_hazard()));
    endtask

    task automatic step();
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.i_issue_valid = 1'b0; bus.i_issue_rd = '0;
        bus.i_rs1_raddr   = '0;   bus.i_rs2_raddr = '0;
        bus.i_alu_valid   = 1'b0; bus.i_alu_rd = '0; bus.i_alu_data = '0;
        bus.i_ld_valid    = 1'b0; bus.i_ld_rd = '0;  bus.i_ld_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();

        // Reset while FIFO holds two entries and busy[5] is set.
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd0;
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd10; bus.i_ld_data = 32'hA;
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd5;
        step();
        bus.i_issue_valid = 1'b0; bus.i_ld_rd = 5'd11;
        step();
        idle();
        bus.i_rs1_raddr = 5'd5;
        #1;
        chk("pre_rst_count", 32'(bus.o_ld_count), 32'd2);
        chk("pre_rst_hazard", 32'(bus.o_hazard), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_count", 32'(bus.o_ld_count), 32'd0);
        chk("rst_ready", 32'(bus.o_ld_ready), 32'd1);
        chk("rst_wen",   32'(bus.o_rd_wen),   32'd0);
        chk("rst_hazard", 32'(bus.o_hazard),  32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();

        // ALU write to a pending register.
        idle();
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd7;
        step();
        idle();
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd7; bus.i_alu_data = 32'hDEADBEEF;
        bus.i_rs1_raddr = 5'd7;
        step();
        idle();
        bus.i_rs1_raddr = 5'd7;
        #1;
        chk("alu_wen",   32'(bus.o_rd_wen),   32'd1);
        chk("alu_waddr", 32'(bus.o_rd_waddr), 32'd7);
        chk("alu_wdata", bus.o_rd_wdata,      32'hDEADBEEF);
        chk("alu_hazard_inflight", 32'(bus.o_hazard), BYP ? 32'd0 : 32'd1);
        step();
        #1 chk("alu_hazard_after", 32'(bus.o_hazard), 32'd0);

        // Fill the FIFO while the ALU holds the port, then drain in order.
        idle();
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd0;
        for (int i = 1; i <= 4; i++) begin
            bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'(i); bus.i_ld_data = 32'h100 + 32'(i);
            step();
        end
        #1;
        chk("full_count", 32'(bus.o_ld_count), 32'd4);
        chk("full_ready", 32'(bus.o_ld_ready), 32'd0);
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            #1;
            chk("drain_waddr", 32'(bus.o_rd_waddr), 32'(i));
            chk("drain_wdata", bus.o_rd_wdata, 32'h100 + 32'(i));
            chk("drain_count", 32'(bus.o_ld_count), 32'(4 - i));
            chk("drain_ready", 32'(bus.o_ld_ready), 32'd1);
        end

        // ALU and FIFO head contend.
        idle();
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd9; bus.i_ld_data = 32'h99;
        step();
        idle();
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd3; bus.i_alu_data = 32'h33;
        step();
        idle();
        #1;
        chk("prio_alu_waddr", 32'(bus.o_rd_waddr), 32'd3);
        chk("prio_alu_count", 32'(bus.o_ld_count), 32'd1);
        step();
        #1;
        chk("prio_ld_waddr", 32'(bus.o_rd_waddr), 32'd9);
        chk("prio_ld_count", 32'(bus.o_ld_count), 32'd0);

        // Load to x0 pops without writing; x0 never pending.
        idle();
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd0; bus.i_ld_data = 32'h1234;
        step();
        idle();
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd0;
        step();
        idle();
        #1;
        chk("x0_wen",    32'(bus.o_rd_wen),   32'd0);
        chk("x0_count",  32'(bus.o_ld_count), 32'd0);
        chk("x0_hazard", 32'(bus.o_hazard),   32'd0);

        // Re-issue to a register on the edge its earlier write retires.
        idle();
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd12;
        step();
        idle();
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd12;
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd12; bus.i_alu_data = 32'h12;
        step();
        idle();
        bus.i_rs2_raddr = 5'd12;
        #1 chk("reissue_hazard_a", 32'(bus.o_hazard), 32'd1);
        step();
        #1 chk("reissue_hazard_b", 32'(bus.o_hazard), 32'd1);
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd12; bus.i_alu_data = 32'h120;
        step();
        bus.i_alu_valid = 1'b0;
        #1 chk("reissue_hazard_c", 32'(bus.o_hazard), BYP ? 32'd0 : 32'd1);
        step();
        #1 chk("reissue_hazard_d", 32'(bus.o_hazard), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.i_issue_valid = ($urandom_range(0, 99) < 30);
            bus.i_issue_rd    = 5'($urandom_range(0, 15));
            bus.i_rs1_raddr   = 5'($urandom_range(0, 15));
            bus.i_rs2_raddr   = 5'($urandom_range(0, 15));
            bus.i_alu_valid   = ($urandom_range(0, 99) < 35);
            bus.i_alu_rd      = 5'($urandom_range(0, 15));
            bus.i_alu_data    = $urandom;
            bus.i_ld_valid    = ($urandom_range(0, 99) < 45);
            bus.i_ld_rd       = 5'($urandom_range(0, 15));
            bus.i_ld_data     = $urandom;
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Writeback-side initiator for the register file's single write port.
- Merges results from a single-cycle ALU path and a variable-latency load path into one registered write stream.
- Load results are buffered in a small FIFO.
- A per-register pending-write scoreboard tells decode when a source operand is not yet readable.
- Sits between the execute/memory stages and the register file.

Parameters:
- DEPTH, 4, load-result FIFO entries; power of two, ≥2.

Ports:
- i_clk  input  1  global clock
- i_rst  input  1  reset, asynchronous, active-high
- i_issue_valid  input  1  instruction with a destination is issuing this cycle
- i_issue_rd  input  5  destination register of the issuing instruction
- i_rs1_raddr  input  5  decode source register 1
- i_rs2_raddr  input  5  decode source register 2
- o_hazard  output  1  combinational; either source is pending
- i_alu_valid  input  1  ALU result valid; always accepted
- i_alu_rd  input  5  ALU destination
- i_alu_data  input  32  ALU result
- i_ld_valid  input  1  load result valid
- o_ld_ready  output  1  FIFO can accept
- i_ld_rd  input  5  load destination
- i_ld_data  input  32  load result
- o_rd_wen  output  1  register file write enable (registered)
- o_rd_waddr  output  5  register file write address (registered)
- o_rd_wdata  output  32  register file write data (registered)
- o_ld_count  output  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async):
  - o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0.
  - FIFO empty, o_ld_count=0, o_ld_ready=1.
  - All busy bits cleared.
- Load enqueue:
  - Load accepted when i_ld_valid && o_ld_ready.
  - o_ld_ready = (count != DEPTH); it does not depend on a same-cycle pop.
- Selection each cycle, priority fixed:
  1. i_alu_valid selects the ALU result.
  2. Otherwise, if the FIFO is non-empty, pop the head.
  3. Otherwise, nothing is selected.
- Output register:
  - The selected entry loads the output register at the clock edge, giving 1-cycle latency.
  - o_rd_wen = selected && rd != 0.
  - Entries with rd=0 still pop but produce no write.
- Simultaneous push and pop: count is unchanged. A push into an empty FIFO cannot pop in the same cycle (no fall-through).
- FIFO storage: pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- Scoreboard, busy[31:0]:
  - busy[0] is hardwired 0.
  - Set on i_issue_valid for i_issue_rd.
  - Cleared at the edge where a write to that rd is selected.
  - Same-edge set and clear of the same register: set wins (newer producer pending).
- Hazard (no bypass): o_hazard = busy[rs1] | busy[rs2] | in-flight match, where in-flight match = o_rd_wen && (o_rd_waddr == rs1 || o_rd_waddr == rs2) with that rs nonzero. The register file does not expose the write until the following edge.
- ALU starvation: sustained ALU traffic can starve the FIFO. Upstream guarantees ALU bubbles; no fairness logic.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: register file instantiated with bypass enabled. The in-flight match term is removed from o_hazard; only busy bits stall.
- Undefined: o_hazard includes the in-flight match as above.

Decomposition:
- Package wb_pkg:
  - XLEN=32, REG_AW=5, NUM_REGS=32.
  - Typedef wb_entry_t {rd[4:0], data[31:0]}.
- Sub-module wb_fifo:
  - Parameterised by DEPTH and the entry type.
  - push/pop/full/empty/count interface.
  - Holds the FIFO state.
- Arbitration, output register and scoreboard stay in wb_unit.

Test Plan:
- Reset while FIFO holds 2 entries and busy[5]=1 → immediately o_ld_count=0, o_ld_ready=1, o_rd_wen=0, o_hazard=0 for rs1=5.
- Issue rd=7; next cycle ALU valid rd=7 data=0xDEADBEEF → one cycle later o_rd_wen=1, waddr=7, wdata=0xDEADBEEF; busy[7]=0. With rs1=7, o_hazard=1 that cycle (0 under WB_BYPASS_EN); 0 the cycle after.
- Push 4 loads rd=1..4 with ALU valid held → o_ld_ready=0 at count=4. Release ALU → writes rd=1,2,3,4 in order on consecutive cycles; ready returns after first pop.
- ALU rd=3 and FIFO head rd=9 in the same cycle → rd=3 written first, rd=9 the next cycle; count drops by 1 only then.
- Load rd=0 data=0x1234 → FIFO pops, o_rd_wen stays 0; issue rd=0 never raises o_hazard.
- Issue rd=12 in the same cycle a pending write to rd=12 is selected → busy[12] remains 1; o_hazard=1 for rs2=12 until the second write is selected.
